// File: rtl/multi_ctrl_pkg.sv
// multi_ctrl_pkg: shared widths, watchdog default and FSM encoding for the multiplier arbiter
package multi_ctrl_pkg;
  localparam int MUL_W = 32;
  localparam int PROD_W = 2 * MUL_W;
  localparam int TIMEOUT_DEF = 34;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first request at or after the pointer, wrapping to 0
module rr_arbiter #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   grant_onehot_o,
  output logic [IDW-1:0] grant_id_o
);
  logic [N-1:0] rot;
  logic [IDW:0] idx;
  // rotate so the pointer sits at bit 0, take the lowest set bit, rotate the index back
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    idx = '0;
    grant_id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx = {1'b0, ptr_i} + (IDW + 1)'(i);
        grant_id_o = (idx >= (IDW + 1)'(N)) ? IDW'(idx - (IDW + 1)'(N)) : idx[IDW-1:0];
      end
    end
    grant_onehot_o = (|req_i) ? N'(1) << grant_id_o : '0;
  end
endmodule

// File: rtl/multi_arbiter.sv
// multi_arbiter: round-robin sharing of one signed multiplier with a watchdog abort
module multi_arbiter
  import multi_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = MUL_W,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_mlier,
  input  logic [NREQ*WIDTH-1:0] req_mcand,
  output logic [NREQ-1:0]       ack,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_prodt,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_mlier,
  output logic [WIDTH-1:0]      mul_mcand,
  input  logic [2*WIDTH-1:0]    mul_prodt,
  input  logic                  mul_valid
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, gnt_id;
  logic [NREQ-1:0] ack_q, ack_d, gnt;
  logic [WDW-1:0] wd_q, wd_d;
  logic start_q, start_d, vld_q, vld_d, err_q, err_d;
  logic [WIDTH-1:0] mlier_q, mlier_d, mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_rr (
    .req_i          (req),
    .ptr_i          (ptr_q),
    .grant_onehot_o (gnt),
    .grant_id_o     (gnt_id)
  );

  // grant in IDLE, wait for valid or watchdog in BUSY, one dead cycle in RESP
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    ack_d = '0;
    wd_d = wd_q;
    start_d = start_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    mlier_d = mlier_q;
    mcand_d = mcand_q;
    prod_d = prod_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = BUSY;
        id_d = gnt_id;
        ack_d = gnt;
        ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        mlier_d = req_mlier[gnt_id*WIDTH +: WIDTH];
        mcand_d = req_mcand[gnt_id*WIDTH +: WIDTH];
        start_d = 1'b1;
        wd_d = WDW'(1);
      end
      BUSY: if (mul_valid || wd_q == WDW'(TIMEOUT)) begin
        state_d = RESP;
        start_d = 1'b0;
        vld_d = 1'b1;
        err_d = !mul_valid;
        prod_d = mul_valid ? mul_prodt : '0;
        wd_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // all state and outputs registered; reset drops any in-flight job silently
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      ack_q <= '0;
      wd_q <= '0;
      start_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      mlier_q <= '0;
      mcand_q <= '0;
      prod_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      ack_q <= ack_d;
      wd_q <= wd_d;
      start_q <= start_d;
      vld_q <= vld_d;
      err_q <= err_d;
      mlier_q <= mlier_d;
      mcand_q <= mcand_d;
      prod_q <= prod_d;
    end
  end

  assign ack = ack_q;
  assign rsp_valid = vld_q;
  assign rsp_id = id_q;
  assign rsp_prodt = prod_q;
  assign rsp_err = err_q;
  assign busy = state_q != IDLE;
  assign mul_start = start_q;
  assign mul_mlier = mlier_q;
  assign mul_mcand = mcand_q;
endmodule

// File: tb/tb_multi_arbiter.sv
// tb_multi_arbiter: scoreboard bench with a variable-latency multiplier model and a round-robin reference
module tb_multi_arbiter;
  import multi_ctrl_pkg::*;
  localparam int N = 4;
  localparam int W = MUL_W;
  localparam int TO = TIMEOUT_DEF;

  typedef struct {
    logic [1:0]        id;
    logic [PROD_W-1:0] p;
    logic              e;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  logic [N-1:0] req;
  logic [N*W-1:0] req_mlier, req_mcand;
  logic [N-1:0] ack;
  logic rsp_valid, rsp_err, busy, mul_start, mul_valid;
  logic [1:0] rsp_id;
  logic [PROD_W-1:0] rsp_prodt, mul_prodt;
  logic [W-1:0] mul_mlier, mul_mcand;

  int tests = 0, fails = 0;
  int cyc = 0, gap = 99, start_cyc = 0, ptr_m = 0;
  logic dead, stray;
  logic [N-1:0] last_ack = '0, prev_req = '0;
  logic [N*W-1:0] prev_ml = '0, prev_mc = '0;
  logic prev_start = 1'b0, prev_rsp = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, exp_a = '0, exp_b = '0;
  logic [W-1:0] jq_a[N][$];
  logic [W-1:0] jq_b[N][$];
  exp_t sb[$];
  int grants[$];
  logic [PROD_W-1:0] rsp_log[$];

  multi_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_mlier(req_mlier), .req_mcand(req_mcand),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prodt(rsp_prodt), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_mlier(mul_mlier), .mul_mcand(mul_mcand),
    .mul_prodt(mul_prodt), .mul_valid(mul_valid)
  );

  always #5 clock = ~clock;

  // behavioural multi_vl: random latency 1..33 per start, valid held while start stays high
  int mcnt, mlat;
  logic mv_q;
  logic [PROD_W-1:0] mp_q;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mv_q <= 1'b0; mp_q <= '0; mcnt <= 0; mlat <= 1;
    end else if (!mul_start) begin
      mv_q <= 1'b0; mcnt <= 0; mlat <= int'($urandom_range(1, 33));
    end else begin
      mcnt <= mcnt + 1;
      if (!dead && mcnt + 1 >= mlat) begin
        mv_q <= 1'b1;
        mp_q <= $signed({{W{mul_mlier[W-1]}}, mul_mlier}) * $signed({{W{mul_mcand[W-1]}}, mul_mcand});
      end
    end
  end
  assign mul_prodt = mp_q;
  assign mul_valid = mv_q | stray;

  function automatic logic [PROD_W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y;
    x = longint'(int'(a));
    y = longint'(int'(b));
    return PROD_W'(x * y);
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      3: return 32'h0;
      default: return W'($urandom());
    endcase
  endfunction

  function automatic bit jobs_pending();
    for (int i = 0; i < N; i++) if (jq_a[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    jq_a[i].push_back(a);
    jq_b[i].push_back(b);
  endtask

  task automatic wait_rsp(input int budget, input string name);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!rsp_valid && n < budget);
    check(name, 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0 || jobs_pending()) && n < budget) begin @(negedge clock); n++; end
    check("wait_idle_bound", 64'(n < budget), 64'd1);
  endtask

  // requesters: hold req while a job is queued, retire the front job the cycle after its ack
  initial begin
    req = '0; req_mlier = '0; req_mcand = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (last_ack[i] && jq_a[i].size() != 0) begin
          void'(jq_a[i].pop_front());
          void'(jq_b[i].pop_front());
        end
        req[i] = jq_a[i].size() != 0;
        req_mlier[i*W +: W] = req[i] ? jq_a[i][0] : '0;
        req_mcand[i*W +: W] = req[i] ? jq_b[i][0] : '0;
      end
    end
  end

  // monitor: predicts each grant from the request snapshot, scores responses and protocol rules
  always @(negedge clock) begin
    cyc++;
    if (reset_n) begin
      if (ack != '0) begin
        int w;
        w = -1;
        check("ack_onehot", 64'($onehot(ack)), 64'd1);
        check("ack_one_cycle", 64'(ack & last_ack), 64'd0);
        check("ack_while_outstanding", 64'(sb.size()), 64'd0);
        for (int k = 0; k < N; k++) if (w < 0 && prev_req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        check("grant_winner", 64'(ack), (w < 0) ? 64'd0 : 64'd1 << w);
        if (w >= 0) begin
          exp_a = prev_ml[w*W +: W];
          exp_b = prev_mc[w*W +: W];
          sb.push_back('{2'(w), dead ? '0 : ref_mul(exp_a, exp_b), dead});
          ptr_m = (w + 1) % N;
          grants.push_back(w);
        end
      end
      if (rsp_valid) begin
        check("rsp_pulse", 64'(prev_rsp), 64'd0);
        check("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t x;
          x = sb.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(x.id));
          check("rsp_prodt", rsp_prodt, x.p);
          check("rsp_err", 64'(rsp_err), 64'(x.e));
          if (x.e) check("timeout_cycles", 64'(cyc - start_cyc), 64'(TO));
          rsp_log.push_back(rsp_prodt);
        end
      end
      if (mul_start && !prev_start) begin
        check("start_gap", 64'(gap >= 2), 64'd1);
        check("start_operands", {mul_mlier, mul_mcand}, {exp_a, exp_b});
        start_cyc = cyc;
        op_a = mul_mlier;
        op_b = mul_mcand;
      end
      if (mul_start) check("operands_stable", {mul_mlier, mul_mcand}, {op_a, op_b});
    end
    gap = mul_start ? 0 : gap + 1;
    last_ack = ack;
    prev_req = req;
    prev_ml = req_mlier;
    prev_mc = req_mcand;
    prev_start = mul_start;
    prev_rsp = rsp_valid;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int g0, n3, n;
    int t2_order[5];
    t2_order = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; dead = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'(|{ack, rsp_valid, rsp_id, rsp_prodt, rsp_err, busy, mul_start, mul_mlier, mul_mcand}), 64'd0);
    #2 reset_n = 1'b1;

    // all requesters active from pointer 0: strict rotation, req[0] held across its ack
    g0 = grants.size();
    rsp_log.delete();
    push(0, 32'h1, 32'hffff_ffff);
    push(0, rnd_op(), rnd_op());
    push(1, 32'h8000_0000, 32'h8000_0000);
    push(2, rnd_op(), rnd_op());
    push(3, rnd_op(), rnd_op());
    wait_idle(400);
    for (int k = 0; k < 5; k++) check("t2_order", 64'((grants.size() > g0 + k) ? grants[g0 + k] : 99), 64'(t2_order[k]));
    check("t2_prod_neg1", (rsp_log.size() > 0) ? rsp_log[0] : '0, 64'hffff_ffff_ffff_ffff);
    check("t2_prod_min", (rsp_log.size() > 1) ? rsp_log[1] : '0, 64'h4000_0000_0000_0000);

    // single request: ack one cycle after req is seen, max-positive square
    push(0, 32'h7fff_ffff, 32'h7fff_ffff);
    @(posedge clock);
    #2;
    @(negedge clock);
    check("t1_no_early_ack", 64'(ack), 64'd0);
    @(negedge clock);
    check("t1_ack_cycle1", 64'(ack), 64'd1);
    check("t1_start", 64'(mul_start), 64'd1);
    wait_rsp(60, "t1_rsp_seen");
    check("t1_prodt", rsp_prodt, 64'h3fff_ffff_0000_0001);
    check("t1_id", 64'(rsp_id), 64'd0);
    check("t1_err", 64'(rsp_err), 64'd0);
    wait_idle(100);

    // dead multiplier: watchdog abort, then a normal job
    dead = 1'b1;
    push(2, rnd_op(), rnd_op());
    wait_rsp(TO + 10, "t3_rsp_seen");
    check("t3_err", 64'(rsp_err), 64'd1);
    check("t3_prodt_zero", rsp_prodt, 64'd0);
    wait_idle(100);
    dead = 1'b0;
    push(3, 32'hffff_fffe, 32'h0000_0003);
    wait_rsp(60, "t3_next_rsp_seen");
    check("t3_next_err", 64'(rsp_err), 64'd0);
    check("t3_next_prodt", rsp_prodt, 64'hffff_ffff_ffff_fffa);
    wait_idle(100);

    // request withdrawn while the arbiter is busy is never granted
    dead = 1'b1;
    push(1, rnd_op(), rnd_op());
    n = 0;
    while (!mul_start && n < 10) begin @(negedge clock); n++; end
    check("t7_started", 64'(mul_start), 64'd1);
    n3 = 0;
    foreach (grants[k]) if (grants[k] == 3) n3++;
    push(3, rnd_op(), rnd_op());
    repeat (3) @(negedge clock);
    jq_a[3].delete();
    jq_b[3].delete();
    wait_idle(200);
    n = 0;
    foreach (grants[k]) if (grants[k] == 3) n++;
    check("t7_no_grant_dropped", 64'(n), 64'(n3));
    dead = 1'b0;

    // stray valid in IDLE produces nothing
    @(posedge clock);
    #1 stray = 1'b1;
    @(posedge clock);
    #1 stray = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("t6_no_rsp", 64'(rsp_valid), 64'd0);
      check("t6_idle", 64'(busy), 64'd0);
    end

    // reset mid-BUSY: outputs clear at once, job dropped, pointer back to 0
    dead = 1'b1;
    push(2, rnd_op(), rnd_op());
    n = 0;
    while (!mul_start && n < 10) begin @(negedge clock); n++; end
    repeat (5) @(negedge clock);
    push(1, rnd_op(), rnd_op());
    push(3, rnd_op(), rnd_op());
    repeat (2) @(negedge clock);
    check("t5_busy_before_reset", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_clear", 64'(|{ack, rsp_valid, rsp_id, rsp_prodt, rsp_err, busy, mul_start, mul_mlier, mul_mcand}), 64'd0);
    sb.delete();
    ptr_m = 0;
    dead = 1'b0;
    repeat (2) @(negedge clock);
    g0 = grants.size();
    #2 reset_n = 1'b1;
    wait_idle(300);
    check("t5_first_after_reset", 64'((grants.size() > g0) ? grants[g0] : 99), 64'd1);

    // random traffic with random multiplier latency
    for (int it = 0; it < 200; it++) begin
      int i;
      i = $urandom_range(0, N - 1);
      if (jq_a[i].size() < 2) push(i, rnd_op(), rnd_op());
      repeat ($urandom_range(0, 12)) @(negedge clock);
    end
    wait_idle(20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
